conv_core_pipe: RTL
===================

Name: conv_core_pipe

Overview:
Parametrised, pipelined successor to the single-row convolution MAC core. Computes o_res = i_sub + sum over s of (pixel_s * kernel_s) for a row of KERNEL_SIZE taps, with a fixed latency of 3 cycles and a valid/stall handshake. Kernel coefficients are held in internal registers loaded by a pulse, so pixel rows can stream every cycle. Cores chain row-to-row through i_sub/o_res inside the convolution engine.

Parameters:
KERNEL_SIZE, 5, number of taps (pixel/kernel pairs) per row, >=1
PIXEL_W, 8, unsigned pixel width
KERNEL_W, 8, unsigned kernel coefficient width
SUB_W, 18, unsigned width of the chained sub-result input
RES_W, 18, unsigned result width
COUNT_W, 16, width of the output sample counter

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous active-high reset
i_valid  in  1  pixel row and sub-result valid this cycle
i_stall  in  1  freeze entire pipeline while high
i_pixel  in  KERNEL_SIZE*PIXEL_W  tap s at bits [s*PIXEL_W +: PIXEL_W]
i_sub  in  SUB_W  sub-result from the previous row core
i_k_ld  in  1  load i_kernel into kernel registers
i_kernel  in  KERNEL_SIZE*KERNEL_W  tap s at bits [s*KERNEL_W +: KERNEL_W]
o_valid  out  1  o_res holds a valid result
o_res  out  RES_W  result
o_sat  out  1  result was saturated (qualified by o_valid)
o_count  out  COUNT_W  number of results produced since reset

Behaviour:
- Reset (rst high at a rising edge): kernel registers, all stage data and valid bits, o_res, o_sat and o_count are cleared to 0. Reset takes priority over i_stall, i_valid and i_k_ld. Reset in mid-stream discards in-flight samples; o_valid is 0 the cycle after reset.
- Kernel load: at an edge with i_k_ld=1, kreg <= i_kernel. The load happens whether or not i_stall is high.
- Same-edge i_k_ld and i_valid: the sample uses the old kreg. The next sample uses the new kreg.
- Stage 1 (edge N): if i_valid and not stalled, register p_s = pixel_s * kreg_s for each s (PIXEL_W+KERNEL_W bits, unsigned) and register i_sub. v1 <= i_valid.
- Stage 2 (edge N+1): register sum of all p_s at full width SUM_W = PIXEL_W+KERNEL_W+clog2(KERNEL_SIZE)+1, and carry sub forward. v2 <= v1.
- Stage 3 (edge N+2): compute total = sum + sub at width max(SUM_W, SUB_W)+1. No bits are dropped before the saturate/wrap step. Register o_res, o_sat and o_valid <= v2.
- Latency: a sample accepted at edge N appears with o_valid=1 after edge N+2, i.e. 3 cycles counting the input cycle. Throughput is 1 sample per cycle. Bubbles (i_valid=0) propagate as o_valid=0.
- Stall: while i_stall=1, every pipeline register including valids and o_res/o_valid holds its value. i_valid is ignored, so the source must hold its data. A consumer takes a result when o_valid=1 and i_stall=0.
- o_count increments by 1 (wrapping modulo 2^COUNT_W) at each edge where stage 3 loads v2=1 while not stalled.
- Data registers for invalid samples may update freely, but o_sat must be 0 whenever o_valid=0.

Optional Feature:
Macro CONV_CORE_SAT_EN.
- Defined: if total > 2^RES_W-1, o_res = 2^RES_W-1 and o_sat=1; otherwise o_res = total and o_sat=0.
- Undefined: o_res = total mod 2^RES_W, and o_sat is tied to 0.

Test Plan:
1. Reset; i_k_ld with all kernel taps = 1; then one sample with pixels 1,2,3,4,5 and sub=10 -> o_valid high for exactly 1 cycle, 3 cycles after the input; o_res=25, o_sat=0, o_count=1.
2. Kernel taps all 255, pixels all 255, sub=0 (total 325125) -> with CONV_CORE_SAT_EN: o_res=262143, o_sat=1; without it: o_res=62981, o_sat=0.
3. Kernel taps = 1, pixels 1..5, sub=0; pulse i_k_ld with taps = 2 on the same edge as a sample, then send an identical sample next cycle -> results 15 then 30 on consecutive cycles.
4. Four back-to-back samples with kernel taps = 1 and pixels all = k (k = 1..4), sub=0 -> o_res 5,10,15,20 on 4 consecutive cycles; o_count=4.
5. Send one sample, then hold i_stall=1 for 2 cycles starting the cycle after it -> result appears 2 cycles later than unstalled. o_res, o_valid and o_count stay frozen during the stall, and o_count increments only once.
6. Three samples in flight, then rst=1 for 1 cycle -> o_valid=0, o_res=0 and o_count=0 after the edge, and no stale result appears afterwards. Kernel registers read back 0: a new sample without i_k_ld gives o_res equal to sub.

Source files
------------

// File: rtl/conv_core_pipe_if.sv
// Bus interface for conv_core_pipe: pixel/sub-result input side, kernel load and result side.
// The core connects through the slave modport and the pixel source through the master modport.
interface conv_core_pipe_if #(
   parameter int unsigned KERNEL_SIZE = 5,
   parameter int unsigned PIXEL_W     = 8,
   parameter int unsigned KERNEL_W    = 8,
   parameter int unsigned SUB_W       = 18,
   parameter int unsigned RES_W       = 18,
   parameter int unsigned COUNT_W     = 16
);
   logic                            i_valid;
   logic                            i_stall;
   logic [KERNEL_SIZE*PIXEL_W-1:0]  i_pixel;
   logic [SUB_W-1:0]                i_sub;
   logic                            i_k_ld;
   logic [KERNEL_SIZE*KERNEL_W-1:0] i_kernel;
   logic                            o_valid;
   logic [RES_W-1:0]                o_res;
   logic                            o_sat;
   logic [COUNT_W-1:0]              o_count;

   modport master (
      output i_valid, i_stall, i_pixel, i_sub, i_k_ld, i_kernel,
      input  o_valid, o_res, o_sat, o_count
   );

   modport slave (
      input  i_valid, i_stall, i_pixel, i_sub, i_k_ld, i_kernel,
      output o_valid, o_res, o_sat, o_count
   );
endinterface

// File: rtl/conv_core_pipe.sv
// Three-stage pipelined row MAC: o_res = i_sub + sum(pixel_s * kernel_s), with stall and kernel load.
// Optional macro CONV_CORE_SAT_EN selects saturation instead of modulo wrap of the result.
module conv_core_pipe #(
   parameter int unsigned KERNEL_SIZE = 5,
   parameter int unsigned PIXEL_W     = 8,
   parameter int unsigned KERNEL_W    = 8,
   parameter int unsigned SUB_W       = 18,
   parameter int unsigned RES_W       = 18,
   parameter int unsigned COUNT_W     = 16
) (
   input  logic           clk,
   input  logic           rst,
   conv_core_pipe_if.slave io_bus
);
   localparam int unsigned PROD_W = PIXEL_W + KERNEL_W;
   localparam int unsigned SUM_W  = PROD_W + $clog2(KERNEL_SIZE) + 1;
   localparam int unsigned TOT_W  = ((SUM_W > SUB_W) ? SUM_W : SUB_W) + 1;

   logic [KERNEL_SIZE*KERNEL_W-1:0] r_kreg;
   logic [PROD_W-1:0]               r_prod [KERNEL_SIZE];
   logic [PROD_W-1:0]               w_prod [KERNEL_SIZE];
   logic [SUB_W-1:0]                r_sub1;
   logic [SUB_W-1:0]                r_sub2;
   logic [SUM_W-1:0]                r_sum2;
   logic [SUM_W-1:0]                w_sum;
   logic                            r_v1;
   logic                            r_v2;
   logic                            r_v3;
   logic [RES_W-1:0]                r_res;
   logic [RES_W-1:0]                w_res;
   logic                            r_sat;
   logic                            w_sat;
   logic [COUNT_W-1:0]              r_count;

   always_comb begin
      for (int s = 0; s < KERNEL_SIZE; s++) begin
         w_prod[s] = PROD_W'(io_bus.i_pixel[s*PIXEL_W +: PIXEL_W]) *
                     PROD_W'(r_kreg[s*KERNEL_W +: KERNEL_W]);
      end
   end

   always_comb begin
      w_sum = '0;
      for (int s = 0; s < KERNEL_SIZE; s++) begin
         w_sum = w_sum + SUM_W'(r_prod[s]);
      end
   end

`ifdef CONV_CORE_SAT_EN
   logic [TOT_W-1:0] w_total;
   assign w_total = TOT_W'(r_sum2) + TOT_W'(r_sub2);

   // Any bit above RES_W set means the total exceeds the largest representable result.
   always_comb begin
      w_sat = |(w_total >> RES_W);
      w_res = w_sat ? {RES_W{1'b1}} : RES_W'(w_total);
   end
`else
   assign w_sat = 1'b0;
   assign w_res = RES_W'(TOT_W'(r_sum2) + TOT_W'(r_sub2));
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_kreg  <= '0;
         r_sub1  <= '0;
         r_sub2  <= '0;
         r_sum2  <= '0;
         r_v1    <= 1'b0;
         r_v2    <= 1'b0;
         r_v3    <= 1'b0;
         r_res   <= '0;
         r_sat   <= 1'b0;
         r_count <= '0;
         for (int s = 0; s < KERNEL_SIZE; s++) r_prod[s] <= '0;
      end else begin
         // Kernel load ignores stall; a same-edge sample still sees the old taps.
         if (io_bus.i_k_ld) r_kreg <= io_bus.i_kernel;
         if (!io_bus.i_stall) begin
            r_v1 <= io_bus.i_valid;
            if (io_bus.i_valid) begin
               for (int s = 0; s < KERNEL_SIZE; s++) r_prod[s] <= w_prod[s];
               r_sub1 <= io_bus.i_sub;
            end
            r_v2   <= r_v1;
            r_sum2 <= w_sum;
            r_sub2 <= r_sub1;
            r_v3   <= r_v2;
            r_res  <= w_res;
            r_sat  <= r_v2 & w_sat;
            if (r_v2) r_count <= r_count + COUNT_W'(1);
         end
      end
   end

   assign io_bus.o_valid = r_v3;
   assign io_bus.o_res   = r_res;
   assign io_bus.o_sat   = r_sat;
   assign io_bus.o_count = r_count;
endmodule
